// File: rtl/pedal_mem_pkg.sv
// Shared definitions for the pedal delay/loop sample-memory sequencer:
// size defaults, frame state encoding and the reverb tap-count clamp.
package pedal_mem_pkg;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_TAPS = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Requested reverb taps, limited to what one frame is allowed to read.
    function automatic int unsigned clamp_taps(input logic [7:0] impulses,
                                               input int unsigned max_taps);
        int unsigned req;
        req = 32'(impulses);
        return (req > max_taps) ? max_taps : req;
    endfunction

endpackage

// File: rtl/delay_mem_scheduler_if.sv
// Bundle of the sample-side control, the tap stream to the mixer and the
// single-port SRAM port owned by the scheduler.
//
// Handshake: sample_valid is a one-cycle strobe with no ready; it is accepted
// only while busy is low, otherwise the sample is dropped and overrun sets.
// tap_valid qualifies tap_idx/tap_data for exactly one cycle per tap and has
// no back-pressure. mem_en/mem_we are single-cycle commands; mem_rdata is
// expected one cycle after a read command.
interface delay_mem_scheduler_if
    import pedal_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_TAPS = DEF_MAX_TAPS
);
    logic                        sample_valid;
    logic [DATA_W-1:0]           sample_in;
    logic                        record;
    logic                        loop;
    logic                        delay_reverb;
    logic [7:0]                  impulses;
    logic [ADDR_W-1:0]           tap_spacing;
    logic                        busy;
    logic                        tap_valid;
    logic [$clog2(MAX_TAPS)-1:0] tap_idx;
    logic [DATA_W-1:0]           tap_data;
    logic                        frame_done;
    logic                        overrun;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  sample_valid, sample_in, record, loop, delay_reverb, impulses,
               tap_spacing, mem_rdata,
        output busy, tap_valid, tap_idx, tap_data, frame_done, overrun,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output sample_valid, sample_in, record, loop, delay_reverb, impulses,
               tap_spacing, mem_rdata,
        input  busy, tap_valid, tap_idx, tap_data, frame_done, overrun,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/tap_addr_gen.sv
// Tap address generator: holds the frame base, walks the read address
// backwards by the tap spacing each read (wrapping naturally at 2^ADDR_W)
// and counts reads so the sequencer knows when the last tap is issued.
module tap_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [ADDR_W-1:0] spacing,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [IDX_W-1:0]  rd_idx,
    output logic              is_last
);
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] spacing_q;
    logic [ADDR_W-1:0] acc_q;
    logic [IDX_W-1:0]  k_q;

    // Load base and first tap address at frame start, then subtract one spacing per read.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            spacing_q <= '0;
            acc_q     <= '0;
            k_q       <= '0;
        end else if (start) begin
            base_q    <= wr_ptr;
            spacing_q <= spacing;
            acc_q     <= wr_ptr - spacing;
            k_q       <= '0;
        end else if (step) begin
            acc_q     <= acc_q - spacing_q;
            k_q       <= k_q + 1'b1;
        end
    end

    assign base    = base_q;
    assign rd_addr = acc_q;
    assign rd_idx  = k_q;
    assign is_last = (k_q == last_idx);

endmodule

// File: rtl/delay_mem_scheduler.sv
// Per-sample sequencer and sole master of the delay/loop sample SRAM:
// optional record write, then back-to-back tap reads streamed to the mixer.
module delay_mem_scheduler
    import pedal_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_TAPS = DEF_MAX_TAPS
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    delay_mem_scheduler_if.slave  bus,
    output state_t                state_dbg
);
    localparam int IDX_W = $clog2(MAX_TAPS);
    localparam int CNT_W = $clog2(MAX_TAPS + 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [DATA_W-1:0] sample_q;
    logic              adv_q;
    logic              has_taps_q;
    logic [IDX_W-1:0]  last_idx_q;
    logic              tap_valid_q;
    logic [IDX_W-1:0]  tap_idx_q;
    logic              overrun_q;

    logic [CNT_W-1:0]  n_req;
    logic              start, step, done;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] base, rd_addr;
    logic [IDX_W-1:0]  rd_idx;
    logic              is_last;

    tap_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .start    (start),
        .step     (step),
        .wr_ptr   (wr_ptr_q),
        .spacing  (bus.tap_spacing),
        .last_idx (last_idx_q),
        .base     (base),
        .rd_addr  (rd_addr),
        .rd_idx   (rd_idx),
        .is_last  (is_last)
    );

    // Tap count of the frame being offered: one in delay mode, clamped impulses in reverb mode.
    always_comb begin
        n_req = CNT_W'(1);
        if (bus.delay_reverb) begin
            n_req = CNT_W'(clamp_taps(bus.impulses, MAX_TAPS));
        end
    end

    // Next-state logic and SRAM command decode; memory is idle outside WRITE and READ.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        step      = 1'b0;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.sample_valid) begin
                    start = 1'b1;
                    if (bus.record)       state_d = ST_WRITE;
                    else if (n_req != '0) state_d = ST_READ;
                    else                  state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base;
                mem_wdata = sample_q;
                state_d   = has_taps_q ? ST_READ : ST_DONE;
            end
            ST_READ: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr;
                step     = 1'b1;
                if (is_last) state_d = ST_WAIT;
            end
            ST_WAIT: state_d = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, frame latches, write pointer, registered tap strobe and sticky overrun.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            sample_q    <= '0;
            adv_q       <= 1'b0;
            has_taps_q  <= 1'b0;
            last_idx_q  <= '0;
            tap_valid_q <= 1'b0;
            tap_idx_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_valid_q <= step;
            tap_idx_q   <= step ? rd_idx : '0;
            if (start) begin
                sample_q   <= bus.sample_in;
                adv_q      <= bus.record | bus.loop;
                has_taps_q <= (n_req != '0);
                last_idx_q <= IDX_W'(n_req - 1'b1);
            end
            if (done && adv_q) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (bus.sample_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.tap_valid  = tap_valid_q;
    assign bus.tap_idx    = tap_idx_q;
    assign bus.tap_data   = tap_valid_q ? bus.mem_rdata : '0;
    assign bus.frame_done = done;
    assign bus.overrun    = overrun_q;
    assign bus.mem_en     = mem_en;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_delay_mem_scheduler.sv
// Bench for delay_mem_scheduler: directed frames from the test plan plus
// randomized frames, checked against a frame-level reference model.
module tb_delay_mem_scheduler;
    import pedal_mem_pkg::*;

    localparam int NEVER = 32'h7fff_ffff;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t state_dbg;
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    bit     mon_on = 1'b0;

    // expected traffic, each entry stamped with the cycle it must appear in
    logic [42:0] exp_mem_q[$];   // {cycle, we, addr, wdata}
    logic [33:0] exp_tap_q[$];   // {cycle, idx, data}
    logic [15:0] exp_done_q[$];  // {cycle}

    logic [15:0] sram   [1024];
    logic [15:0] shadow [1024];
    logic [9:0]  m_wr_ptr = '0;
    int          bs = 0, be = -1;
    int          ov_from = NEVER;

    logic        r_rec, r_lp, r_dr;
    logic [7:0]  r_imp;
    logic [9:0]  r_sp;
    int          r_n, r_span, r_drop;

    delay_mem_scheduler_if #(.ADDR_W(10), .DATA_W(16), .MAX_TAPS(4)) bus ();

    delay_mem_scheduler #(.ADDR_W(10), .DATA_W(16), .MAX_TAPS(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: synchronous write, read data one cycle after the read
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata      <= sram[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs_word();
        return 64'({bus.busy, bus.tap_valid, bus.frame_done, bus.overrun, bus.mem_en,
                    bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.tap_idx, bus.tap_data});
    endfunction

    // monitor: pops and compares whenever the DUT presents memory traffic, a tap or frame end
    always @(negedge clk) begin : monitor
        logic eb;
        logic [42:0] am;
        logic [33:0] at;
        if (mon_on) begin
            eb = (cyc >= bs) && (cyc <= be);
            check("busy", 64'(bus.busy), 64'(eb));
            check("state_idle", 64'(state_dbg == ST_IDLE), 64'(!eb));
            check("overrun", 64'(bus.overrun), 64'(cyc >= ov_from));
            if (bus.mem_en) begin
                am = {16'(cyc), bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 16'h0};
                if (exp_mem_q.size() == 0) check("mem_unexpected", 64'(am), '1);
                else                       check("mem_access", 64'(am), 64'(exp_mem_q.pop_front()));
            end
            if (bus.tap_valid) begin
                at = {16'(cyc), bus.tap_idx, bus.tap_data};
                if (exp_tap_q.size() == 0) check("tap_unexpected", 64'(at), '1);
                else                       check("tap", 64'(at), 64'(exp_tap_q.pop_front()));
            end
            if (bus.frame_done) begin
                if (exp_done_q.size() == 0) check("done_unexpected", 64'(cyc), '1);
                else                        check("frame_done", 64'(cyc), 64'(exp_done_q.pop_front()));
            end
        end
    end

    task automatic randomize_side();
        bus.record       = 1'($urandom_range(0, 1));
        bus.loop         = 1'($urandom_range(0, 1));
        bus.delay_reverb = 1'($urandom_range(0, 1));
        bus.impulses     = 8'($urandom);
        bus.tap_spacing  = 10'($urandom);
        bus.sample_in    = 16'($urandom);
    endtask

    function automatic int taps_of(input logic dr, input logic [7:0] imp);
        if (!dr) return 1;
        return (int'(imp) > 4) ? 4 : int'(imp);
    endfunction

    // driver + reference model: strobe a frame, predict its traffic, hold until it ends
    task automatic issue_frame(input logic rec, input logic lp, input logic dr,
                               input logic [7:0] imp, input logic [9:0] sp,
                               input logic [15:0] smp, input int drop_at, input int gap);
        int c0, w, n, done_c;
        logic [9:0] base, a;
        repeat (gap) begin
            @(posedge clk); #1;
            bus.sample_valid = 1'b0;
            randomize_side();
        end
        c0 = cyc;
        bus.sample_valid = 1'b1;
        bus.record = rec; bus.loop = lp; bus.delay_reverb = dr;
        bus.impulses = imp; bus.tap_spacing = sp; bus.sample_in = smp;
        w = rec ? 1 : 0;
        n = taps_of(dr, imp);
        base = m_wr_ptr;
        if (rec) begin
            shadow[base] = smp;
            exp_mem_q.push_back({16'(c0 + 1), 1'b1, base, smp});
        end
        for (int k = 1; k <= n; k++) begin
            a = 10'((int'(base) - k * int'(sp)) & 1023);
            exp_mem_q.push_back({16'(c0 + w + k), 1'b0, a, 16'h0});
            exp_tap_q.push_back({16'(c0 + 1 + w + k), 2'(k - 1), shadow[a]});
        end
        done_c = (n > 0) ? c0 + 2 + w + n : c0 + 1 + w;
        exp_done_q.push_back(16'(done_c));
        bs = c0 + 1;
        be = done_c;
        if (rec || lp) m_wr_ptr = m_wr_ptr + 10'd1;
        while (cyc <= done_c) begin
            @(posedge clk); #1;
            bus.sample_valid = 1'b0;
            randomize_side();
            if (drop_at > 0 && cyc == c0 + drop_at && cyc <= done_c) begin
                bus.sample_valid = 1'b1;
                if (ov_from > cyc + 1) ov_from = cyc + 1;
            end
        end
    endtask

    // 4-tap recording frame with reset pulsed in its second cycle (first read)
    task automatic reset_mid_frame(input logic [9:0] sp, input logic [15:0] smp);
        int c0;
        logic [9:0] base;
        c0 = cyc;
        bus.sample_valid = 1'b1;
        bus.record = 1'b1; bus.loop = 1'b0; bus.delay_reverb = 1'b1;
        bus.impulses = 8'd4; bus.tap_spacing = sp; bus.sample_in = smp;
        base = m_wr_ptr;
        shadow[base] = smp;
        exp_mem_q.push_back({16'(c0 + 1), 1'b1, base, smp});
        exp_mem_q.push_back({16'(c0 + 2), 1'b0, base - sp, 16'h0});
        bs = c0 + 1;
        be = c0 + 2;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        randomize_side();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ov_from = NEVER;
        m_wr_ptr = '0;
        @(negedge clk);
        check("midreset_outputs", outs_word(), 64'h0);
        check("midreset_state", 64'(state_dbg), 64'(ST_IDLE));
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]   = 16'((i * 40503 + 7) ^ (i << 5));
            shadow[i] = 16'((i * 40503 + 7) ^ (i << 5));
        end
        bus.sample_valid = 1'b0;
        randomize_side();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", outs_word(), 64'h0);
        check("reset_state", 64'(state_dbg), 64'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        mon_on = 1'b1;

        // pointer-only frames (loop, no taps) bring wr_ptr to 5
        repeat (5) issue_frame(1'b0, 1'b1, 1'b1, 8'd0, 10'd7, 16'h0, 0, 0);
        // record, delay mode, spacing 3: write 5, read 2
        issue_frame(1'b1, 1'b0, 1'b0, 8'd0, 10'd3, 16'h1234, 0, 1);
        repeat (44) issue_frame(1'b0, 1'b1, 1'b1, 8'd0, 10'd1, 16'h0, 0, 0);
        // reverb, 7 impulses clamp to 4, base 50, spacing 100
        issue_frame(1'b0, 1'b1, 1'b1, 8'd7, 10'd100, 16'hbeef, 0, 0);
        repeat (972) issue_frame(1'b0, 1'b1, 1'b1, 8'd0, 10'd1, 16'h0, 0, 0);
        // record at 1023, pointer wraps, spacing 1 from base 0 reads 1023
        issue_frame(1'b1, 1'b0, 1'b0, 8'd0, 10'd5, 16'h5a5a, 0, 2);
        issue_frame(1'b0, 1'b0, 1'b0, 8'd3, 10'd1, 16'h0, 0, 0);
        // nothing to do: no memory access, done in cycle 1, pointer held
        issue_frame(1'b0, 1'b0, 1'b1, 8'd0, 10'd9, 16'h0, 0, 1);
        issue_frame(1'b1, 1'b0, 1'b0, 8'd0, 10'd0, 16'h7777, 0, 0);
        // strobe during READ is dropped; overrun sticks through later frames
        issue_frame(1'b1, 1'b0, 1'b1, 8'd3, 10'd17, 16'hc0de, 2, 1);
        issue_frame(1'b0, 1'b1, 1'b1, 8'd2, 10'd200, 16'h0, 0, 0);
        // reset mid-frame, then the next record lands at address 0
        reset_mid_frame(10'd33, 16'habcd);
        issue_frame(1'b1, 1'b0, 1'b0, 8'd0, 10'd4, 16'h0fed, 0, 0);
        // strobe in the DONE cycle is also dropped
        issue_frame(1'b0, 1'b0, 1'b1, 8'd0, 10'd4, 16'h0, 1, 0);

        for (int i = 0; i < 250; i++) begin
            r_rec = 1'($urandom_range(0, 1));
            r_lp  = 1'($urandom_range(0, 1));
            r_dr  = 1'($urandom_range(0, 1));
            r_imp = 8'($urandom_range(0, 9));
            r_sp  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
            r_n   = taps_of(r_dr, r_imp);
            r_span = (r_n > 0) ? 2 + int'(r_rec) + r_n : 1 + int'(r_rec);
            r_drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, r_span)) : 0;
            issue_frame(r_rec, r_lp, r_dr, r_imp, r_sp, 16'($urandom), r_drop,
                        int'($urandom_range(0, 2)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("mem_queue_drained", 64'(exp_mem_q.size()), 64'h0);
        check("tap_queue_drained", 64'(exp_tap_q.size()), 64'h0);
        check("done_queue_drained", 64'(exp_done_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
